// File: rtl/bus_cycle_ctrl_pkg.sv
// bus_cycle_ctrl_pkg: shared state codes and default sizing for the bus cycle controller
package bus_cycle_ctrl_pkg;
  typedef enum logic [1:0] {
    BUS_CYC_IDLE   = 2'd0,
    BUS_CYC_ACCESS = 2'd1,
    BUS_CYC_DONE   = 2'd2,
    BUS_CYC_ERR    = 2'd3
  } bus_cyc_t;
  localparam int BUS_SLAVE_BITS  = 3;
  localparam int BUS_TIMEOUT_DEF = 15;
endpackage

// File: rtl/bus_addr_dec.sv
// bus_addr_dec: maps the address MSBs to a slave index and a one-hot chip select
module bus_addr_dec #(
  parameter int ADDR_W     = 30,
  parameter int SLAVE_BITS = 3
) (
  input  logic [ADDR_W-1:0]          i_addr,
  output logic [SLAVE_BITS-1:0]      o_sel,
  output logic [2**SLAVE_BITS-1:0]   o_cs
);
  localparam int NS = 2**SLAVE_BITS;
  logic w_unused;
  assign o_sel    = i_addr[ADDR_W-1 -: SLAVE_BITS];
  assign o_cs     = NS'(1) << o_sel;
  assign w_unused = ^i_addr[ADDR_W-SLAVE_BITS-1:0];
endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences one slave transfer for the granted master, with wait counting and timeout
module bus_cycle_ctrl
  import bus_cycle_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int SLAVE_BITS = BUS_SLAVE_BITS,
  parameter int TIMEOUT    = BUS_TIMEOUT_DEF,
  parameter int TO_W       = 4
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       m_as,
  input  logic                       m_rw,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [2**SLAVE_BITS-1:0]   s_rdy,
  output logic [2**SLAVE_BITS-1:0]   s_cs,
  output logic                       s_as,
  output logic                       s_rw,
  output logic                       m_rdy,
  output logic                       m_err,
  output logic                       busy
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
  bus_cyc_t                  r_state;
  logic [TO_W-1:0]           r_cnt;
  logic [SLAVE_BITS-1:0]     r_sel;
  logic [SLAVE_BITS-1:0]     w_sel;
  logic [2**SLAVE_BITS-1:0]  w_cs;
  bus_addr_dec #(.ADDR_W(ADDR_W), .SLAVE_BITS(SLAVE_BITS)) u_dec (
    .i_addr (m_addr),
    .o_sel  (w_sel),
    .o_cs   (w_cs)
  );
  always_ff @(posedge clk) begin
    if (!rest) begin
      r_state <= BUS_CYC_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      s_cs    <= '0;
      s_as    <= 1'b0;
      s_rw    <= 1'b0;
      m_rdy   <= 1'b0;
      m_err   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      m_rdy <= 1'b0;
      m_err <= 1'b0;
      case (r_state)
        BUS_CYC_IDLE:
          if (m_as) begin
            r_state <= BUS_CYC_ACCESS;
            r_sel   <= w_sel;
            r_cnt   <= '0;
            s_cs    <= w_cs;
            s_as    <= 1'b1;
            s_rw    <= m_rw;
            busy    <= 1'b1;
          end else begin
            s_cs <= '0;
            s_as <= 1'b0;
            s_rw <= 1'b0;
            busy <= 1'b0;
          end
        BUS_CYC_ACCESS:
          if (!m_as) begin
            r_state <= BUS_CYC_IDLE;
            s_cs    <= '0;
            s_as    <= 1'b0;
            s_rw    <= 1'b0;
            busy    <= 1'b0;
          end else if (s_rdy[r_sel]) begin
            r_state <= BUS_CYC_DONE;
            m_rdy   <= 1'b1;
            s_cs    <= '0;
            s_as    <= 1'b0;
            s_rw    <= 1'b0;
          end else if (TIMEOUT != 0 && r_cnt == LAST) begin
            r_state <= BUS_CYC_ERR;
            m_err   <= 1'b1;
            s_cs    <= '0;
            s_as    <= 1'b0;
            s_rw    <= 1'b0;
          end else begin
            // saturate so a disabled timeout never wraps the counter
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
          end
        default: begin
          r_state <= BUS_CYC_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule
